seg7_freq_display: RTL and testbench



---
 rtl/seg7_pkg.sv | 66 ++++++
 rtl/seg7_freq_display_bin2bcd.sv | 58 +++++
 rtl/seg7_freq_display.sv | 169 ++++++++++++++++
 tb/tb_seg7_freq_display.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment frequency display.
// Segment codes are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

    localparam int DIGIT_W    = 4;
    localparam int BCD_W      = 20;
    localparam int BIN_W      = 16;
    localparam int NUM_DIGITS = 4;

    localparam logic [3:0] ITER_LAST = 4'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } conv_state_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Non-decimal nibble codes stored in the display register
    localparam logic [DIGIT_W-1:0] NIB_DASH  = 4'hA;
    localparam logic [DIGIT_W-1:0] NIB_BLANK = 4'hF;

    function automatic logic [6:0] seg_decode(input logic [DIGIT_W-1:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:     s = SEG_0;
            4'd1:     s = SEG_1;
            4'd2:     s = SEG_2;
            4'd3:     s = SEG_3;
            4'd4:     s = SEG_4;
            4'd5:     s = SEG_5;
            4'd6:     s = SEG_6;
            4'd7:     s = SEG_7;
            4'd8:     s = SEG_8;
            4'd9:     s = SEG_9;
            NIB_DASH: s = SEG_DASH;
            default:  s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Add 3 to every BCD nibble that is 5 or more, ahead of the shift
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int i = 0; i < BCD_W / DIGIT_W; i++) begin
            if (r[i*DIGIT_W +: DIGIT_W] >= 4'd5) begin
                r[i*DIGIT_W +: DIGIT_W] = r[i*DIGIT_W +: DIGIT_W] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_freq_display_bin2bcd.sv
// Sequential double-dabble engine: one adjust+shift per clock, 16 clocks.
// done pulses for one cycle when bcd_out holds the finished result.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             done,
    output logic [BCD_W-1:0] bcd_out
);

    logic [BIN_W-1:0]       bin_q;
    logic [BCD_W-1:0]       bcd_q;
    logic [3:0]             iter_q;
    logic                   active_q;
    logic                   done_q;
    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W+BIN_W-1:0] shift_d;

    // Adjust the accumulator, then shift the {bcd, bin} pair left by one
    always_comb begin
        bcd_adj = dabble_adjust(bcd_q);
        shift_d = {bcd_adj, bin_q} << 1;
    end

    // Load on start, otherwise run the 16 shift iterations
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            iter_q   <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                bin_q    <= bin_in;
                bcd_q    <= '0;
                iter_q   <= '0;
                active_q <= 1'b1;
            end else if (active_q) begin
                bcd_q  <= shift_d[BCD_W+BIN_W-1 -: BCD_W];
                bin_q  <= shift_d[BIN_W-1:0];
                iter_q <= iter_q + 4'd1;
                if (iter_q == ITER_LAST) begin
                    active_q <= 1'b0;
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign done    = done_q;
    assign bcd_out = bcd_q;

endmodule

// File: rtl/seg7_freq_display.sv
// Frequency display: binary->BCD conversion, display register, anode scan.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits 3..1.
module seg7_freq_display
    import seg7_pkg::*;
#(
    parameter int CLK_HZ      = 100000000,
    parameter int REFRESH_DIV = 100000,
    parameter int MAX_DISPLAY = 9999
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [BIN_W-1:0] displayed_number,
    output logic [3:0]       anode,
    output logic [6:0]       cathode,
    output logic             DP,
    output logic             busy
);

    // A divider below 2 (or a nonsense clock) falls back to the minimum
    localparam int DIV_N = (REFRESH_DIV < 2 || CLK_HZ <= 0) ? 2 : REFRESH_DIV;
    localparam int DIV_W = $clog2(DIV_N);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_N - 1);
    localparam logic [BIN_W-1:0] MAX_Q    = BIN_W'(MAX_DISPLAY);
    localparam logic [15:0]      DASH_WORD = {NUM_DIGITS{NIB_DASH}};

    conv_state_e      state_q;
    logic [BIN_W-1:0] held_q;
    logic             first_q;
    logic [3:0]       iter_q;
    logic             busy_q;
    logic             overflow_q;
    logic [15:0]      disp_q;

    logic             start;
    logic             conv_done;
    logic [BCD_W-1:0] bcd_out;
    logic             over;
    logic [15:0]      commit_digits;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [1:0]       idx_q;
    logic [1:0]       idx_d;
    logic             div_wrap;
    logic [3:0]       sel_nib;

    logic [3:0]       anode_q;
    logic [6:0]       cathode_q;
    logic             dp_q;

    assign start = (state_q == IDLE) &&
                   (first_q || (displayed_number != held_q));

    bin2bcd_seq u_bin2bcd (
        .CLK     (CLK),
        .RST     (RST),
        .start   (start),
        .bin_in  (displayed_number),
        .done    (conv_done),
        .bcd_out (bcd_out)
    );

    // A nonzero ten-thousands nibble can never fit four digits
    assign over = (held_q > MAX_Q) ||
                  (bcd_out[BCD_W-1 -: DIGIT_W] != '0);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic lead;

    // Blank zero digits from the left until the first nonzero one
    always_comb begin
        commit_digits = bcd_out[15:0];
        lead          = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lead && (commit_digits[i*DIGIT_W +: DIGIT_W] == 4'd0)) begin
                commit_digits[i*DIGIT_W +: DIGIT_W] = NIB_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
    end
`else
    // All four digits shown, leading zeros included
    always_comb begin
        commit_digits = bcd_out[15:0];
    end
`endif

    // Converter FSM: latch on change, wait out the shifts, commit atomically
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            held_q     <= '0;
            first_q    <= 1'b1;
            iter_q     <= '0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            disp_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        held_q  <= displayed_number;
                        first_q <= 1'b0;
                        iter_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    iter_q <= iter_q + 4'd1;
                    if (iter_q == ITER_LAST) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (conv_done) begin
                        disp_q     <= over ? DASH_WORD : commit_digits;
                        overflow_q <= over;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Next divider count and digit index
    always_comb begin
        div_wrap = (div_q == DIV_LAST);
        div_d    = div_wrap ? '0 : div_q + DIV_W'(1);
        idx_d    = div_wrap ? idx_q + 2'd1 : idx_q;
    end

    // Refresh divider and digit index registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_q <= '0;
            idx_q <= '0;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
        end
    end

    assign sel_nib = disp_q[{idx_q, 2'b00} +: DIGIT_W];

    // Registered pin drivers for the selected digit
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            anode_q   <= 4'b1111;
            cathode_q <= SEG_BLANK;
            dp_q      <= 1'b1;
        end else begin
            anode_q   <= ~(4'b0001 << idx_q);
            cathode_q <= seg_decode(sel_nib);
            dp_q      <= ~(overflow_q && (idx_q == 2'd0));
        end
    end

    assign anode   = anode_q;
    assign cathode = cathode_q;
    assign DP      = dp_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_seg7_freq_display.sv
// Self-checking bench for seg7_freq_display with a value scoreboard.
// Honours SEG7_LEADING_ZERO_BLANK_EN when building expected digits.
module tb_seg7_freq_display;

    localparam int RD = 3;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] displayed_number;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic        DP;
    logic        busy;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int exp_q[$];

    seg7_freq_display #(
        .CLK_HZ      (100000000),
        .REFRESH_DIV (RD),
        .MAX_DISPLAY (9999)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .displayed_number (displayed_number),
        .anode            (anode),
        .cathode          (cathode),
        .DP               (DP),
        .busy             (busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic model(input int v, output logic [27:0] ec,
                         output logic [3:0] edp);
        int d[4];
        bit lead;
        d[0] = v % 10;
        d[1] = (v / 10) % 10;
        d[2] = (v / 100) % 10;
        d[3] = (v / 1000) % 10;
        edp = 4'hF;
        for (int i = 0; i < 4; i++) ec[i*7 +: 7] = seg_of(d[i]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        lead = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (lead && d[i] == 0) ec[i*7 +: 7] = 7'b1111111;
            else lead = 1'b0;
        end
`else
        lead = 1'b0;
`endif
        if (v > 9999) begin
            ec  = {4{7'b0111111}};
            edp = 4'b1110;
        end
    endtask

    task automatic wait_busy_high(input string tag);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge CLK);
            if (busy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s busy_rise: busy=%b after 40 cycles, want 1", tag, busy);
        end
    endtask

    // Waits for busy to rise then fall; lat counts negedges up to the fall
    task automatic wait_commit(input string tag, input bit watch,
                               output int lat, output int bhigh,
                               output int odd, output bit ok);
        bit seen_hi;
        lat = 0; bhigh = 0; odd = 0; ok = 1'b0; seen_hi = 1'b0;
        for (int n = 1; n <= 80; n++) begin
            @(negedge CLK);
            if (watch && cathode !== 7'b1000000 && cathode !== 7'b1111111)
                odd++;
            if (busy === 1'b1) begin
                seen_hi = 1'b1;
                bhigh++;
            end else if (seen_hi) begin
                lat = n;
                ok  = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s commit_timeout: no busy fall in 80 cycles, busy=%b", tag, busy);
        end
    endtask

    // Pops the next expected value and checks one full scan of the display
    task automatic check_frame(input string tag);
        int v, idx, run, bad_oh, bad_seq, bad_run, bad_st;
        bit first_run;
        logic [27:0] ec, cc;
        logic [3:0] edp, cdp, seen, prev, oh;
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s scoreboard: commit seen, queue empty, want 1 entry", tag);
            return;
        end
        v = exp_q.pop_front();
        model(v, ec, edp);
        cc = '1; cdp = '1; seen = '0; prev = '1;
        bad_oh = 0; bad_seq = 0; bad_run = 0; bad_st = 0;
        run = 0; first_run = 1'b1; idx = 0;
        @(negedge CLK);
        for (int n = 0; n < 4*RD + 1; n++) begin
            @(negedge CLK);
            oh = ~anode;
            if ($countones(oh) != 1) begin
                bad_oh++;
            end else begin
                for (int k = 0; k < 4; k++) if (oh[k]) idx = k;
                if (seen[idx] && (cc[idx*7 +: 7] !== cathode || cdp[idx] !== DP))
                    bad_st++;
                cc[idx*7 +: 7] = cathode;
                cdp[idx] = DP;
                seen[idx] = 1'b1;
            end
            if (n == 0) begin
                run = 1;
            end else if (anode !== prev) begin
                if (anode !== {prev[2:0], prev[3]}) bad_seq++;
                if (!first_run && run != RD) bad_run++;
                first_run = 1'b0;
                run = 1;
            end else begin
                run++;
            end
            prev = anode;
        end
        checks++;
        if (bad_oh != 0) begin
            fails++;
            $display("FAIL %s anode_onehot: %0d bad samples, want 0", tag, bad_oh);
        end
        checks++;
        if (bad_seq != 0 || seen !== 4'hF) begin
            fails++;
            $display("FAIL %s scan_order: %0d bad steps, seen=%b, want 0 and 1111", tag, bad_seq, seen);
        end
        checks++;
        if (bad_run != 0) begin
            fails++;
            $display("FAIL %s slot_length: %0d slots not %0d cycles, want 0", tag, bad_run, RD);
        end
        checks++;
        if (bad_st != 0) begin
            fails++;
            $display("FAIL %s digit_stable: %0d changes in a frame, want 0", tag, bad_st);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cc[k*7 +: 7] !== ec[k*7 +: 7] || cdp[k] !== edp[k]) begin
                fails++;
                $display("FAIL %s value %0d digit%0d: cathode=%b DP=%b, want %b DP=%b",
                         tag, v, k, cc[k*7 +: 7], cdp[k], ec[k*7 +: 7], edp[k]);
            end
        end
    endtask

    task automatic check_timing(input string tag, input int lat, input int bhigh);
        checks++;
        if (lat != 18) begin
            fails++;
            $display("FAIL %s latency: %0d cycles, want 18", tag, lat);
        end
        checks++;
        if (bhigh != 17) begin
            fails++;
            $display("FAIL %s busy_len: %0d cycles, want 17", tag, bhigh);
        end
    endtask

    task automatic check_reset_pins(input string tag);
        checks++;
        if (anode !== 4'b1111 || cathode !== 7'b1111111 || DP !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s reset_pins: anode=%b cathode=%b DP=%b busy=%b, want 1111 1111111 1 0",
                     tag, anode, cathode, DP, busy);
        end
    endtask

    task automatic test_reset();
        int lat, bh, odd;
        bit ok;
        RST = 1'b1;
        displayed_number = 16'd0;
        repeat (3) @(negedge CLK);
        check_reset_pins("reset");
        exp_q.push_back(0);
        RST = 1'b0;
        wait_commit("reset", 1'b0, lat, bh, odd, ok);
        check_timing("reset", lat, bh);
        check_frame("reset");
    endtask

    task automatic test_convert(input int v, input string tag);
        int lat, bh, odd;
        bit ok;
        displayed_number = 16'(v);
        exp_q.push_back(v);
        wait_commit(tag, 1'b0, lat, bh, odd, ok);
        check_timing(tag, lat, bh);
        check_frame(tag);
    endtask

    task automatic test_overflow();
        test_convert(9999, "max9999");
        test_convert(10000, "ovf10000");
        test_convert(65535, "ovf65535");
    endtask

    task automatic test_hold();
        int hi;
        test_convert(42, "hold42");
        hi = 0;
        repeat (1000) begin
            @(negedge CLK);
            if (busy !== 1'b0) hi++;
        end
        checks++;
        if (hi != 0) begin
            fails++;
            $display("FAIL hold busy_idle: busy high %0d cycles, want 0", hi);
        end
        exp_q.push_back(42);
        check_frame("hold_after");
    endtask

    task automatic test_back_to_back();
        int lat, bh, odd, c0;
        bit ok;
        displayed_number = 16'd1234;
        c0 = cyc;
        exp_q.push_back(1234);
        wait_busy_high("b2b");
        repeat (4) @(negedge CLK);
        displayed_number = 16'd500;
        exp_q.push_back(500);
        wait_commit("b2b_first", 1'b0, lat, bh, odd, ok);
        check_frame("b2b_first");
        wait_commit("b2b_second", 1'b0, lat, bh, odd, ok);
        checks++;
        if (cyc - c0 > 36) begin
            fails++;
            $display("FAIL b2b total: %0d cycles, want <= 36", cyc - c0);
        end
        check_frame("b2b_second");
    endtask

    task automatic test_reset_mid();
        int lat, bh, odd;
        bit ok;
        displayed_number = 16'd4321;
        wait_busy_high("rstmid");
        repeat (7) @(negedge CLK);
        RST = 1'b1;
        #1;
        check_reset_pins("rstmid");
        @(negedge CLK);
        check_reset_pins("rstmid_held");
        RST = 1'b0;
        exp_q.push_back(4321);
        wait_commit("rstmid", 1'b1, lat, bh, odd, ok);
        check_timing("rstmid", lat, bh);
        checks++;
        if (odd != 0) begin
            fails++;
            $display("FAIL rstmid partial: %0d samples not 0/blank, want 0", odd);
        end
        check_frame("rstmid");
    endtask

    initial begin
        RST = 1'b1;
        displayed_number = 16'd0;
        test_reset();
        test_convert(1234, "digits1234");
        test_overflow();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
